// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// memory request channel. Conflicts alternate between requesters, and every
// access is bounded by a wait counter that forces completion with all-ones data
// and a sticky bus_err flag when memory never acknowledges.
module mem_port_arbiter #(
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = 15
) (
  input  logic          g_clk,
  input  logic          g_clr,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_odv,
  output logic [DW-1:0] i_data,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_odv,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          bus_err
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

  // Last BUSY cycle before the counter forces completion.
  localparam logic [7:0] CntLast = 8'(TMO - 1);

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;  // 1: data port had the most recent grant
  logic          gnt_d_q, gnt_d_d;    // 1: current access belongs to the data port
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic          m_we_q, m_we_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_data_q, i_data_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          take_d;

  // Arbitration, access bookkeeping and completion capture.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    cnt_d     = cnt_q;
    m_addr_d  = m_addr_q;
    m_we_d    = m_we_q;
    m_wdata_d = m_wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = bus_err_q;
    take_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          // On conflict the port that did not win last time is served.
          take_d   = d_req && (!i_req || !last_d_q);
          state_d  = take_d ? StBusyD : StBusyI;
          last_d_d = take_d;
          gnt_d_d  = take_d;
          cnt_d    = '0;
          if (take_d) begin
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_wdata;
          end else begin
            m_addr_d  = i_addr;
            m_we_d    = 1'b0;
            m_wdata_d = '0;
          end
        end
      end
      StBusyI, StBusyD: begin
        if (m_ack) begin
          // An ack on the final counted cycle still wins over the timeout.
          state_d = StDone;
          if (state_q == StBusyI) begin
            i_data_d = m_rdata;
          end else if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          bus_err_d = 1'b1;
          if (state_q == StBusyI) begin
            i_data_d = '1;
          end else if (!m_we_q) begin
            d_rdata_d = '1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      cnt_q     <= '0;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_wdata_q <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      cnt_q     <= cnt_d;
      m_addr_q  <= m_addr_d;
      m_we_q    <= m_we_d;
      m_wdata_q <= m_wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    m_req = (state_q == StBusyI) || (state_q == StBusyD);
    i_odv = (state_q == StDone) && !gnt_d_q;
    d_odv = (state_q == StDone) && gnt_d_q;
  end

  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder plays back per-transaction
// latency/data chosen at issue time, and a monitor scores completions against
// a transaction-level model of the two ports.
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;
  localparam int NR  = 30;

  logic          g_clk = 1'b0;
  logic          g_clr;
  logic          i_req, i_odv;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          d_req, d_we, d_odv;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          bus_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .i_req(i_req), .i_addr(i_addr), .i_odv(i_odv), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_odv(d_odv), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
  );

  always #5 g_clk = ~g_clk;

  // lat = BUSY cycle in which memory acks (1..TMO), 0 = never ack.
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
  } txn_t;

  txn_t cur_i, cur_d, acc;
  txn_t q_i[$];
  txn_t q_d[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   acc_len = 0;
  bit   who_d = 1'b0;
  bit   end_now = 1'b0;
  bit   mon_on = 1'b0;
  bit   exp_i_odv = 1'b0, exp_d_odv = 1'b0;
  logic [15:0] mdl_idata = '0, mdl_drd = '0;
  logic        mdl_err = 1'b0;
  logic [15:0] cap_addr, cap_wdata;
  logic        cap_we;
  bit   rand_go = 1'b0, i_fin = 1'b0, d_fin = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue_i(input logic [15:0] a, input int lat, input logic [15:0] rd);
    txn_t t;
    t.addr = a; t.we = 1'b0; t.wdata = '0; t.lat = lat; t.rdata = rd;
    cur_i = t;
    q_i.push_back(t);
    i_addr = a;
    i_req  = 1'b1;
  endtask

  task automatic issue_d(input logic [15:0] a, input logic we, input logic [15:0] wd,
                         input int lat, input logic [15:0] rd);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.lat = lat; t.rdata = rd;
    cur_d = t;
    q_d.push_back(t);
    d_addr  = a;
    d_we    = we;
    d_wdata = wd;
    d_req   = 1'b1;
  endtask

  function automatic int rand_lat();
    int sel;
    sel = int'($urandom % 8);
    if (sel == 0) return 0;
    if (sel == 1) return TMO;
    return 1 + int'($urandom % 4);
  endfunction

  // Wait for this port's completion pulse; n = posedges until it appears.
  task automatic wait_odv(input bit is_d, input string nm, output int n);
    n = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge g_clk);
      #1;
      if (is_d ? d_odv : i_odv) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL %s: odv not seen within 300 cycles, required one pulse", nm);
    end
  endtask

  task automatic flush_model();
    q_i.delete();
    q_d.delete();
    grant_q.delete();
    mdl_idata = '0;
    mdl_drd   = '0;
    mdl_err   = 1'b0;
    exp_i_odv = 1'b0;
    exp_d_odv = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_m_req"},   32'(m_req),   32'd0);
    chk({nm, "_m_we"},    32'(m_we),    32'd0);
    chk({nm, "_m_addr"},  32'(m_addr),  32'd0);
    chk({nm, "_m_wdata"}, 32'(m_wdata), 32'd0);
    chk({nm, "_i_odv"},   32'(i_odv),   32'd0);
    chk({nm, "_d_odv"},   32'(d_odv),   32'd0);
    chk({nm, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({nm, "_i_data"},  32'(i_data),  32'd0);
    chk({nm, "_d_rdata"}, 32'(d_rdata), 32'd0);
  endtask

  // Memory responder: identifies the granted transaction, checks the request
  // stays stable, and acks on the transaction's chosen BUSY cycle.
  initial begin
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge g_clk);
      #2;
      end_now = 1'b0;
      if (m_req === 1'b1) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          checks++;
          if (d_req && m_we === cur_d.we && m_addr === cur_d.addr &&
              (!cur_d.we || m_wdata === cur_d.wdata)) begin
            who_d = 1'b1;
            acc = cur_d;
          end else if (i_req && m_we === 1'b0 && m_addr === cur_i.addr) begin
            who_d = 1'b0;
            acc = cur_i;
          end else begin
            errors++;
            $display("FAIL grant_id: m_addr %h m_we %b m_wdata %h matches no pending request",
                     m_addr, m_we, m_wdata);
            who_d = 1'b0;
            acc = cur_i;
          end
          grant_q.push_back(int'(who_d));
          cap_addr = m_addr;
          cap_we = m_we;
          cap_wdata = m_wdata;
        end else begin
          chk("m_hold", {m_we, m_wdata, m_addr[14:0]}, {cap_we, cap_wdata, cap_addr[14:0]});
        end
        chk("m_req_len_le_tmo", 32'(busy_cnt <= TMO), 32'd1);
        if (acc.lat == busy_cnt) begin
          m_ack = 1'b1;
          m_rdata = acc.rdata;
          end_now = 1'b1;
        end else begin
          m_ack = 1'b0;
          m_rdata = 16'($urandom);
          if (busy_cnt == TMO) end_now = 1'b1;
        end
      end else begin
        if (busy_cnt > 0) acc_len = busy_cnt;
        busy_cnt = 0;
        m_ack = 1'($urandom % 2);  // stray acks outside BUSY must be ignored
        m_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: every cycle compares pulses and held outputs with the model.
  initial begin
    txn_t t;
    logic [15:0] e;
    forever begin
      @(posedge g_clk);
      #3;
      if (mon_on) begin
        chk("i_odv_timing", 32'(i_odv), 32'(exp_i_odv));
        chk("d_odv_timing", 32'(d_odv), 32'(exp_d_odv));
        if (i_odv === 1'b1) begin
          checks++;
          if (q_i.size() == 0) begin
            errors++;
            $display("FAIL i_unexpected: i_odv with no outstanding fetch, required none");
          end else begin
            t = q_i.pop_front();
            e = (t.lat != 0) ? t.rdata : 16'hFFFF;
            mdl_idata = e;
            if (t.lat == 0) mdl_err = 1'b1;
          end
        end
        if (d_odv === 1'b1) begin
          checks++;
          if (q_d.size() == 0) begin
            errors++;
            $display("FAIL d_unexpected: d_odv with no outstanding access, required none");
          end else begin
            t = q_d.pop_front();
            if (!t.we) mdl_drd = (t.lat != 0) ? t.rdata : 16'hFFFF;
            if (t.lat == 0) mdl_err = 1'b1;
          end
        end
        chk("i_data", 32'(i_data), 32'(mdl_idata));
        chk("d_rdata", 32'(d_rdata), 32'(mdl_drd));
        chk("bus_err", 32'(bus_err), 32'(mdl_err));
      end
      exp_i_odv = end_now && !who_d && !g_clr;
      exp_d_odv = end_now && who_d && !g_clr;
    end
  end

  // Random instruction-fetch agent.
  initial begin
    int gap, n;
    wait (rand_go);
    for (int k = 0; k < NR; k++) begin
      gap = int'($urandom % 3);
      if (gap > 0) begin
        i_req = 1'b0;
        repeat (gap) @(posedge g_clk);
        #1;
      end
      issue_i(16'($urandom) & 16'hFFFE, rand_lat(), 16'($urandom));
      wait_odv(1'b0, "rand_i", n);
    end
    i_req = 1'b0;
    i_fin = 1'b1;
  end

  // Random data agent; writes always get an ack.
  initial begin
    int gap, n, lat;
    logic we;
    wait (rand_go);
    for (int k = 0; k < NR; k++) begin
      gap = int'($urandom % 3);
      if (gap > 0) begin
        d_req = 1'b0;
        repeat (gap) @(posedge g_clk);
        #1;
      end
      we = 1'($urandom % 2);
      lat = rand_lat();
      if (we && lat == 0) lat = 1;
      issue_d(16'($urandom) | 16'h0001, we, 16'($urandom), lat, 16'($urandom));
      wait_odv(1'b1, "rand_d", n);
    end
    d_req = 1'b0;
    d_fin = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_i, t_d;
    bit ok;
    g_clr = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge g_clk);
    #1;
    flush_model();
    check_reset_outputs("reset");
    g_clr = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;

    // Single fetch: odv two cycles after the request is first sampled.
    issue_i(16'h0040, 1, 16'h1234);
    grant_q.delete();
    wait_odv(1'b0, "single_fetch", n);
    i_req = 1'b0;
    chk("single_fetch_latency", 32'(n), 32'd2);
    chk("single_fetch_grant", 32'(grant_q.size()), 32'd1);
    repeat (3) @(posedge g_clk);
    #1;

    // Conflict right after reset-era I grant: D goes first.
    grant_q.delete();
    issue_d(16'h0100, 1'b1, 16'h00FF, 1, 16'hDEAD);
    issue_i(16'h0200, 1, 16'h5555);
    t_i = -1;
    t_d = -1;
    for (int c = 1; c <= 100 && (t_i < 0 || t_d < 0); c++) begin
      @(posedge g_clk);
      #1;
      if (i_odv && t_i < 0) begin t_i = c; i_req = 1'b0; end
      if (d_odv && t_d < 0) begin t_d = c; d_req = 1'b0; end
    end
    chk("conflict_order", 32'(t_d > 0 && t_i > t_d), 32'd1);
    chk("conflict_first_is_d", 32'(grant_q.size() == 2 && grant_q[0] == 1 && grant_q[1] == 0),
        32'd1);
    chk("conflict_d_rdata_kept", 32'(d_rdata), 32'd0);
    repeat (3) @(posedge g_clk);
    #1;

    // Both requesters held for four grants: D, I, D, I.
    grant_q.delete();
    issue_d(16'h0301, 1'b0, 16'h0000, 1 + int'($urandom % 3), 16'h1111);
    issue_i(16'h0402, 1 + int'($urandom % 3), 16'h2222);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge g_clk);
      #1;
      if (i_odv) begin
        if (grant_q.size() < 4) issue_i(16'h0402 + 16'(grant_q.size() * 4), 2, 16'($urandom));
        else i_req = 1'b0;
      end
      if (d_odv) begin
        if (grant_q.size() < 4)
          issue_d(16'h0301 + 16'(grant_q.size() * 4), 1'b0, 16'h0, 1, 16'($urandom));
        else d_req = 1'b0;
      end
      if (!i_req && !d_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("alternate_done", 32'(ok), 32'd1);
    chk("alternate_order", {grant_q[0][7:0], grant_q[1][7:0], grant_q[2][7:0], grant_q[3][7:0]},
        32'h01000100);
    repeat (3) @(posedge g_clk);
    #1;

    // Ack landing on the last counted cycle is a normal completion.
    issue_d(16'h0501, 1'b0, 16'h0, TMO, 16'hABCD);
    wait_odv(1'b1, "ack_on_tmo", n);
    d_req = 1'b0;
    chk("ack_on_tmo_rdata", 32'(d_rdata), 32'h0000ABCD);
    chk("ack_on_tmo_bus_err", 32'(bus_err), 32'd0);
    repeat (2) @(posedge g_clk);
    #1;
    chk("ack_on_tmo_len", 32'(acc_len), 32'(TMO));

    // Timeout: no ack at all.
    issue_d(16'h0601, 1'b0, 16'h0, 0, 16'h0);
    wait_odv(1'b1, "timeout", n);
    d_req = 1'b0;
    chk("timeout_rdata", 32'(d_rdata), 32'h0000FFFF);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    repeat (2) @(posedge g_clk);
    #1;
    chk("timeout_len", 32'(acc_len), 32'(TMO));

    // Randomized traffic on both ports.
    rand_go = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge g_clk);
      #1;
      if (i_fin && d_fin) begin
        ok = 1'b1;
        break;
      end
    end
    chk("random_done", 32'(ok), 32'd1);
    repeat (3) @(posedge g_clk);
    #1;
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // Clear in the middle of a fetch; the held request is re-arbitrated.
    issue_i(16'h0700, 10, 16'h7777);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge g_clk);
      #1;
      if (m_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midreset_started", 32'(ok), 32'd1);
    repeat (2) @(posedge g_clk);
    #1;
    g_clr = 1'b1;
    @(posedge g_clk);
    #1;
    flush_model();
    q_i.push_back(cur_i);
    check_reset_outputs("midreset");
    g_clr = 1'b0;
    wait_odv(1'b0, "midreset_regrant", n);
    i_req = 1'b0;
    chk("midreset_one_grant", 32'(grant_q.size()), 32'd1);
    chk("midreset_i_data", 32'(i_data), 32'h00007777);
    repeat (3) @(posedge g_clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
